// File: rtl/sdio_pkg.sv
// Shared SDIO clock generator definitions.
// State encodings are also read by the host status register.
package sdio_pkg;

  localparam logic [1:0] SDIO_CLK_OFF   = 2'd0;
  localparam logic [1:0] SDIO_CLK_RUN   = 2'd1;
  localparam logic [1:0] SDIO_CLK_PAUSE = 2'd2;
  localparam logic [1:0] SDIO_CLK_INIT  = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF   = SDIO_CLK_OFF,
    ST_RUN   = SDIO_CLK_RUN,
    ST_PAUSE = SDIO_CLK_PAUSE,
    ST_INIT  = SDIO_CLK_INIT
  } clk_st_e;

endpackage

// File: rtl/sdio_clk_gen.sv
// SD/SDIO card clock generator, divider updates aligned to period boundary.
// Define SDIO_CLK_INIT_SEQ_EN to build the power-up init clock burst.
module sdio_clk_gen #(
  parameter int               DIV_W    = 8,
  parameter logic [DIV_W-1:0] DIV_RST  = {DIV_W{1'b1}},
  parameter int               INIT_CYC = 74,
  parameter int               INIT_W   = 7
) (
  input  logic             sd_clk,
  input  logic             rstn,
  input  logic             clk_en,
  input  logic             pause,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_upd,
  output logic             div_busy,
  output logic             div_ack,
  input  logic             init_start,
  output logic             init_busy,
  output logic             init_done,
  output logic             clk_o,
  output logic             clk_oe,
  output logic             tx_en,
  output logic             rx_en,
  output logic [1:0]       clk_state
);
  import sdio_pkg::*;

  clk_st_e          state, state_d;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic [DIV_W-1:0] div_act, div_pend;
  logic             clk_d, oe_d;
  logic             term, burst, run, apply;
  logic             start, fin;

  assign term      = cnt == div_act;
  assign burst     = state == ST_INIT;
  assign run       = (state == ST_RUN) || burst;
  assign clk_state = state;

  assign apply = div_busy &&
                 ((state == ST_OFF) || (state == ST_PAUSE) ||
                  (run && term && clk_o));

  // Strobes only announce edges that will really happen.
  assign tx_en = run & term & clk_o;
  assign rx_en = run & term & ~clk_o &
                 (burst | (clk_en & ~pause));

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    clk_d   = clk_o;
    oe_d    = clk_oe;
    unique case (state)
      ST_OFF: begin
        if (start || clk_en) begin
          state_d = start ? ST_INIT : ST_RUN;
          oe_d    = 1'b1;
          cnt_d   = '0;
          clk_d   = 1'b0;
        end
      end
      ST_PAUSE: begin
        if (!clk_en) begin
          state_d = ST_OFF;
          oe_d    = 1'b0;
          cnt_d   = '0;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (clk_o) begin
          if (term) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (!burst || fin) begin
              if (!clk_en) begin
                state_d = ST_OFF;
                oe_d    = 1'b0;
              end else if (pause) begin
                state_d = ST_PAUSE;
              end else begin
                state_d = ST_RUN;
              end
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end else if (!burst && !clk_en) begin
          state_d = ST_OFF;
          oe_d    = 1'b0;
          cnt_d   = '0;
        end else if (!burst && pause) begin
          state_d = ST_PAUSE;
        end else if (term) begin
          cnt_d = '0;
          clk_d = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
    endcase
    if (start && state != ST_OFF) begin
      state_d = ST_INIT;
      oe_d    = 1'b1;
    end
  end

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_OFF;
      cnt      <= '0;
      clk_o    <= 1'b0;
      clk_oe   <= 1'b0;
      div_act  <= DIV_RST;
      div_pend <= DIV_RST;
      div_busy <= 1'b0;
      div_ack  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      clk_o   <= clk_d;
      clk_oe  <= oe_d;
      div_ack <= apply;
      if (apply) begin
        div_act  <= div_pend;
        div_busy <= 1'b0;
      end
      // A fresh request wins over a same-cycle apply.
      if (div_upd) begin
        div_pend <= div_in;
        div_busy <= 1'b1;
      end
    end
  end

`ifdef SDIO_CLK_INIT_SEQ_EN
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYC);

  logic [INIT_W-1:0] init_cnt;

  assign start = init_start & ~burst;
  assign fin   = init_cnt == INIT_LAST;

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      init_cnt  <= '0;
      init_busy <= 1'b0;
      init_done <= 1'b0;
    end else begin
      init_done <= burst & clk_o & term & fin;
      if (start) begin
        init_cnt  <= '0;
        init_busy <= 1'b1;
      end else if (burst & ~clk_o & term) begin
        init_cnt <= init_cnt + 1'b1;
      end
      if (burst & clk_o & term & fin) begin
        init_busy <= 1'b0;
      end
    end
  end
`else
  localparam int unused_init_cfg = INIT_CYC + INIT_W;
  logic unused_init;

  assign unused_init = init_start;
  assign start       = 1'b0;
  assign fin         = 1'b0;
  assign init_busy   = 1'b0;
  assign init_done   = 1'b0;
`endif

endmodule

// File: tb/tb_sdio_clk_gen.sv
// Directed bench for sdio_clk_gen: per-cycle model compare plus
// hand-computed period, pause, stop, burst and reset expectations.
module tb_sdio_clk_gen;

  localparam int DIV_RST  = 255;
  localparam int INIT_CYC = 74;
`ifdef SDIO_CLK_INIT_SEQ_EN
  localparam bit INIT_ON = 1'b1;
`else
  localparam bit INIT_ON = 1'b0;
`endif

  logic       sd_clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clk_en = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] div_in = 8'd0;
  logic       div_upd = 1'b0;
  logic       init_start = 1'b0;
  logic       div_busy, div_ack, init_busy, init_done;
  logic       clk_o, clk_oe, tx_en, rx_en;
  logic [1:0] clk_state;

  int checks = 0;
  int errors = 0;

  always #5 sd_clk = ~sd_clk;

  sdio_clk_gen dut (
    .sd_clk    (sd_clk),
    .rstn      (rstn),
    .clk_en    (clk_en),
    .pause     (pause),
    .div_in    (div_in),
    .div_upd   (div_upd),
    .div_busy  (div_busy),
    .div_ack   (div_ack),
    .init_start(init_start),
    .init_busy (init_busy),
    .init_done (init_done),
    .clk_o     (clk_o),
    .clk_oe    (clk_oe),
    .tx_en     (tx_en),
    .rx_en     (rx_en),
    .clk_state (clk_state)
  );

  // Model: mode, cycles spent in current half period, level, divider.
  logic [1:0] m_mode, n_mode;
  int         m_pos, n_pos, m_div, n_div, m_pend, n_pend;
  int         m_rises, n_rises, half;
  bit         m_hi, n_hi, m_oe, n_oe, m_busy, n_busy;
  bit         m_ack, n_ack, m_done, n_done;
  bit         last, burst, running, go_init, falling, applies, finish;
  logic [9:0] exp_v, act_v;

  always begin
    @(negedge sd_clk);
    #2;
    if (!rstn) begin
      m_mode = 2'd0; m_pos = 0; m_div = DIV_RST; m_pend = DIV_RST;
      m_rises = 0; m_hi = 0; m_oe = 0; m_busy = 0; m_ack = 0; m_done = 0;
    end
    n_mode = m_mode; n_pos = m_pos; n_hi = m_hi; n_oe = m_oe;
    n_rises = m_rises; n_div = m_div; n_pend = m_pend; n_busy = m_busy;
    n_ack = 0; n_done = 0;
    if (rstn) begin
      half    = m_div + 1;
      last    = (m_pos + 1 == half);
      burst   = (m_mode == 2'd3);
      running = (m_mode == 2'd1) || burst;
      falling = running && m_hi && last;
      applies = m_busy && (m_mode == 2'd0 || m_mode == 2'd2 || falling);
      go_init = INIT_ON && init_start && !burst;
      finish  = 0;
      case (m_mode)
        2'd0: if (go_init || clk_en) begin
          n_mode = go_init ? 2'd3 : 2'd1;
          n_oe = 1; n_pos = 0; n_hi = 0;
        end
        2'd2: begin
          if (!clk_en) begin n_mode = 2'd0; n_oe = 0; n_pos = 0; end
          else if (!pause) n_mode = 2'd1;
        end
        default: begin
          if (m_hi) begin
            if (last) begin
              n_hi = 0; n_pos = 0;
              finish = burst && (m_rises == INIT_CYC);
              if (!burst || finish) begin
                if (!clk_en) begin n_mode = 2'd0; n_oe = 0; end
                else n_mode = pause ? 2'd2 : 2'd1;
              end
            end else n_pos = m_pos + 1;
          end else if (!burst && !clk_en) begin
            n_mode = 2'd0; n_oe = 0; n_pos = 0;
          end else if (!burst && pause) begin
            n_mode = 2'd2;
          end else if (last) begin
            n_hi = 1; n_pos = 0;
            if (burst) n_rises = m_rises + 1;
          end else n_pos = m_pos + 1;
        end
      endcase
      if (go_init && m_mode != 2'd0) begin n_mode = 2'd3; n_oe = 1; end
      if (go_init) n_rises = 0;
      if (applies) begin n_div = m_pend; n_busy = 0; n_ack = 1; end
      if (div_upd) begin n_pend = int'(div_in); n_busy = 1; end
      n_done = finish;
    end
    exp_v = {m_hi, m_oe, m_mode, m_busy, m_ack, (m_mode == 2'd3), m_done,
             (m_hi && !n_hi), (!m_hi && n_hi)};
    act_v = {clk_o, clk_oe, clk_state, div_busy, div_ack, init_busy,
             init_done, tx_en, rx_en};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_model t=%0t {clk_o,oe,state,busy,ack,ibusy,idone,tx,rx} got %b expected %b",
               $time, act_v, exp_v);
    end
    m_mode = n_mode; m_pos = n_pos; m_hi = n_hi; m_oe = n_oe;
    m_rises = n_rises; m_div = n_div; m_pend = n_pend; m_busy = n_busy;
    m_ack = n_ack; m_done = n_done;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Negedges advanced until clk_o reaches level v.
  task automatic wait_lvl(input logic v, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge sd_clk);
      n++;
    end while (clk_o !== v && n < maxc);
    if (clk_o !== v) begin
      checks++;
      errors++;
      $display("FAIL wait_clk_o: level %0b not reached in %0d cycles got %b", v, maxc, clk_o);
    end
  endtask

  task automatic set_div(input logic [7:0] d);
    @(negedge sd_clk);
    div_in  = d;
    div_upd = 1'b1;
    @(negedge sd_clk);
    div_upd = 1'b0;
  endtask

  initial begin
    int n;
    int rises;
    logic prev;
    repeat (2) @(negedge sd_clk);
    chk("rst_clk_o", clk_o, 0);
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_state", clk_state, 0);
    rstn = 1'b1;

    set_div(8'd1);
    chk("off_upd_busy", div_busy, 1);
    @(negedge sd_clk);
    chk("off_ack", div_ack, 1);
    chk("off_busy_clr", div_busy, 0);
    clk_en = 1'b1;
    @(negedge sd_clk);
    chk("run_oe", clk_oe, 1);
    chk("run_state", clk_state, 1);
    wait_lvl(1'b1, 20, n); chk("div1_first_low", n, 2);
    wait_lvl(1'b0, 20, n); chk("div1_high", n, 2);
    wait_lvl(1'b1, 20, n); chk("div1_low", n, 2);

    div_in  = 8'd3;
    div_upd = 1'b1;
    @(negedge sd_clk);
    div_upd = 1'b0;
    chk("mid_high_busy", div_busy, 1);
    chk("mid_high_lvl", clk_o, 1);
    @(negedge sd_clk);
    chk("fall_ack", div_ack, 1);
    chk("fall_busy_clr", div_busy, 0);
    chk("fall_lvl", clk_o, 0);
    wait_lvl(1'b1, 20, n); chk("div3_low", n, 4);
    wait_lvl(1'b0, 20, n); chk("div3_high", n, 4);

    div_in  = 8'd2;
    div_upd = 1'b1;
    @(negedge sd_clk);
    div_upd = 1'b0;
    wait_lvl(1'b1, 20, n);
    wait_lvl(1'b0, 20, n);
    wait_lvl(1'b1, 20, n); chk("div2_low", n, 3);
    pause = 1'b1;
    wait_lvl(1'b0, 20, n); chk("pause_high", n, 3);
    chk("pause_state", clk_state, 2);
    repeat (10) @(negedge sd_clk);
    chk("pause_held_lvl", clk_o, 0);
    chk("pause_held_oe", clk_oe, 1);
    pause = 1'b0;
    wait_lvl(1'b1, 20, n); chk("resume_low", n, 4);

    clk_en = 1'b0;
    wait_lvl(1'b0, 20, n); chk("stop_high", n, 3);
    chk("stop_oe", clk_oe, 0);
    chk("stop_state", clk_state, 0);
    clk_en = 1'b1;
    repeat (2) @(negedge sd_clk);
    clk_en = 1'b0;
    @(negedge sd_clk);
    chk("low_stop_state", clk_state, 0);
    chk("low_stop_oe", clk_oe, 0);
    chk("low_stop_lvl", clk_o, 0);

    set_div(8'd0);
    @(negedge sd_clk);
    init_start = 1'b1;
    @(negedge sd_clk);
    init_start = 1'b0;
    if (INIT_ON) begin
      chk("init_busy", init_busy, 1);
      chk("init_state", clk_state, 3);
      rises = 0;
      prev  = clk_o;
      for (int i = 0; i < 400 && !init_done; i++) begin
        @(negedge sd_clk);
        if (clk_o && !prev) rises++;
        prev = clk_o;
      end
      chk("init_done_seen", init_done, 1);
      chk("init_rises", rises, INIT_CYC);
      chk("init_end_lvl", clk_o, 0);
      chk("init_end_state", clk_state, 0);
      chk("init_end_busy", init_busy, 0);
    end else begin
      @(negedge sd_clk);
      chk("noinit_state", clk_state, 0);
      chk("noinit_busy", init_busy, 0);
    end

    set_div(8'd3);
    @(negedge sd_clk);
    clk_en = 1'b1;
    wait_lvl(1'b1, 20, n);
    div_in  = 8'd5;
    div_upd = 1'b1;
    @(negedge sd_clk);
    div_upd = 1'b0;
    chk("pre_rst_busy", div_busy, 1);
    chk("pre_rst_lvl", clk_o, 1);
    @(posedge sd_clk);
    #3 rstn = 1'b0;
    #1;
    chk("async_rst_lvl", clk_o, 0);
    chk("async_rst_oe", clk_oe, 0);
    chk("async_rst_busy", div_busy, 0);
    @(negedge sd_clk);
    @(negedge sd_clk);
    rstn = 1'b1;
    wait_lvl(1'b1, 600, n); chk("rst_div_low", n, 257);
    wait_lvl(1'b0, 600, n); chk("rst_div_high", n, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
